// File: rtl/calc_pipe_pkg.sv
// rtl/calc_pipe_pkg.sv - operator enum and helper functions for calc_pipe_unit
package calc_pipe_pkg;

  // Operators are evaluated at this width and then truncated, so WIDTH may be at most MAX_W.
  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_MUL    = 2'd2,
    OP_SATADD = 2'd3
  } op_e;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [MAX_W-1:0] calc_op(input op_e op, input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b, input int unsigned w);
    logic [2*MAX_W-1:0] wa, wb, full, mask;
    wa   = {{MAX_W{1'b0}}, a};
    wb   = {{MAX_W{1'b0}}, b};
    mask = ((2*MAX_W)'(1) << w) - (2*MAX_W)'(1);
    case (op)
      OP_SUB:  full = wa - wb;
      OP_MUL:  full = wa * wb;
      default: full = wa + wb;
    endcase
    if ((op == OP_SATADD) && (full > mask)) full = mask;
    full = full & mask;
    return full[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/calc_pipe_fifo.sv
// rtl/calc_pipe_fifo.sv - DEPTH x WIDTH synchronous result queue, pointers wrap modulo DEPTH
module calc_pipe_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_enq, do_deq;

  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign do_deq = deq & ~empty;
  assign do_enq = enq & (~full | do_deq);
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_enq) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_deq) rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PW'(1);
    if (do_enq && !do_deq) cnt_d = cnt_q + CW'(1);
    else if (!do_enq && do_deq) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset: entries are only visible through cnt_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/calc_pipe_unit.sv
// rtl/calc_pipe_unit.sv - start/result/check method block over a 2-stage pipe and result queue
module calc_pipe_unit
  import calc_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OP    = 0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [WIDTH-1:0]          start_a,
  input  logic [WIDTH-1:0]          start_b,
  output logic                      RDY_start,
  input  logic                      stenable_,
  input  logic [WIDTH-1:0]          result_c,
  output logic [WIDTH-1:0]          result,
  output logic                      RDY_result,
  input  logic [WIDTH-1:0]          check_d,
  output logic [WIDTH-1:0]          check,
  output logic                      RDY_check,
  input  logic                      chenable_,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OW     = occ_w(DEPTH);
  localparam op_e         OP_SEL = op_e'(OP[1:0]);

  logic             rst_sync_q, rst_sync_d;
  logic             pipe_valid_q, pipe_valid_d;
  logic [WIDTH-1:0] pipe_data_q, pipe_data_d;
  logic [OW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_empty, fifo_full;
  logic             start_fire, check_fire;
  logic             unused_fifo_full;

  assign unused_fifo_full = fifo_full;

  // Credit count covers the pipe register too, so the queue can never overflow.
  assign RDY_start  = rst_sync_q & (count_q < OW'(DEPTH));
  assign RDY_result = ~fifo_empty;
  assign RDY_check  = ~fifo_empty;
  assign start_fire = stenable_ & RDY_start;
  assign check_fire = chenable_ & RDY_check;
  assign result     = RDY_result ? (fifo_head + result_c) : '0;
  assign check      = RDY_check ? (fifo_head ^ check_d) : '0;
  assign occupancy  = count_q;

  always_comb begin
    rst_sync_d   = 1'b1;
    pipe_valid_d = start_fire;
    pipe_data_d  = pipe_data_q;
    count_d      = count_q;
    if (start_fire) begin
      pipe_data_d = WIDTH'(calc_op(OP_SEL, MAX_W'(start_a), MAX_W'(start_b), WIDTH));
    end
    if (start_fire && !check_fire) count_d = count_q + OW'(1);
    else if (!start_fire && check_fire) count_d = count_q - OW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync_q   <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      count_q      <= '0;
    end else begin
      rst_sync_q   <= rst_sync_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      count_q      <= count_d;
    end
  end

  calc_pipe_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .enq      (pipe_valid_q),
    .enq_data (pipe_data_q),
    .deq      (check_fire),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_calc_pipe_unit.sv
// tb/tb_calc_pipe_unit.sv - randomized and directed bench for calc_pipe_unit against a queue model
module tb_calc_pipe_unit;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0]  a8 = '0, b8 = '0, rc8 = '0, cd8 = '0;
  logic        st8 = 1'b0, ch8 = 1'b0;
  logic        rs8 [4];
  logic        rr8 [4];
  logic        rk8 [4];
  logic [7:0]  res8 [4];
  logic [7:0]  ck8 [4];
  logic [2:0]  occ8 [4];

  logic [15:0] a16 = '0, b16 = '0, rc16 = '0, cd16 = '0;
  logic        st16 = 1'b0, ch16 = 1'b0;
  logic        rs16, rr16, rk16;
  logic [15:0] res16, ck16;
  logic [1:0]  occ16;

  for (genvar g = 0; g < 4; g++) begin : g_op
    calc_pipe_unit #(.WIDTH(8), .DEPTH(4), .OP(g)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .start_a(a8), .start_b(b8), .RDY_start(rs8[g]),
      .stenable_(st8), .result_c(rc8), .result(res8[g]), .RDY_result(rr8[g]),
      .check_d(cd8), .check(ck8[g]), .RDY_check(rk8[g]), .chenable_(ch8),
      .occupancy(occ8[g])
    );
  end

  calc_pipe_unit #(.WIDTH(16), .DEPTH(3), .OP(2)) u_dut16 (
    .CLK(CLK), .RST_N(RST_N), .start_a(a16), .start_b(b16), .RDY_start(rs16),
    .stenable_(st16), .result_c(rc16), .result(res16), .RDY_result(rr16),
    .check_d(cd16), .check(ck16), .RDY_check(rk16), .chenable_(ch16),
    .occupancy(occ16)
  );

  typedef struct {
    longint unsigned a;
    longint unsigned b;
    int              avail;
  } ent_t;

  ent_t q8[$];
  ent_t q16[$];
  int   edges = 0;
  bit   live = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge CLK) edges <= edges + 1;
  always @(posedge CLK or negedge RST_N) live <= RST_N;

  function automatic longint unsigned ref_op(input int op, input longint unsigned a,
                                             input longint unsigned b, input int w);
    longint unsigned m;
    m = 64'd1 << w;
    case (op)
      0:       return (a + b) % m;
      1:       return (a + m - b) % m;
      2:       return (a * b) % m;
      default: return (a + b > m - 1) ? m - 1 : a + b;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s8, input logic c8, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] rc, input logic [7:0] cd,
                      input logic s16 = 1'b0, input logic c16 = 1'b0,
                      input logic [15:0] aw = '0, input logic [15:0] bw = '0,
                      input logic [15:0] rcw = '0, input logic [15:0] cdw = '0);
    int              e0;
    bit              ers8, err8, ers16, err16;
    longint unsigned hd;
    @(negedge CLK);
    st8 = s8; ch8 = c8; a8 = a; b8 = b; rc8 = rc; cd8 = cd;
    st16 = s16; ch16 = c16; a16 = aw; b16 = bw; rc16 = rcw; cd16 = cdw;
    #1;
    e0    = edges;
    ers8  = live && (q8.size() < 4);
    err8  = (q8.size() > 0) && (q8[0].avail <= e0);
    ers16 = live && (q16.size() < 3);
    err16 = (q16.size() > 0) && (q16[0].avail <= e0);
    for (int g = 0; g < 4; g++) begin
      hd = err8 ? ref_op(g, q8[0].a, q8[0].b, 8) : 0;
      check_eq($sformatf("rdy_start op%0d", g), 64'(rs8[g]), 64'(ers8));
      check_eq($sformatf("rdy_result op%0d", g), 64'(rr8[g]), 64'(err8));
      check_eq($sformatf("rdy_check op%0d", g), 64'(rk8[g]), 64'(err8));
      check_eq($sformatf("occupancy op%0d", g), 64'(occ8[g]), 64'(q8.size()));
      check_eq($sformatf("result op%0d", g), 64'(res8[g]), err8 ? (hd + rc) % 256 : 0);
      check_eq($sformatf("check op%0d", g), 64'(ck8[g]), err8 ? (hd ^ 64'(cd)) : 0);
    end
    hd = err16 ? ref_op(2, q16[0].a, q16[0].b, 16) : 0;
    check_eq("rdy_start w16", 64'(rs16), 64'(ers16));
    check_eq("rdy_result w16", 64'(rr16), 64'(err16));
    check_eq("occupancy w16", 64'(occ16), 64'(q16.size()));
    check_eq("result w16", 64'(res16), err16 ? (hd + rcw) % 65536 : 0);
    check_eq("check w16", 64'(ck16), err16 ? (hd ^ 64'(cdw)) : 0);
    @(posedge CLK);
    if (c8 && err8) void'(q8.pop_front());
    if (s8 && ers8) q8.push_back('{a: a, b: b, avail: e0 + 2});
    if (c16 && err16) void'(q16.pop_front());
    if (s16 && ers16) q16.push_back('{a: aw, b: bw, avail: e0 + 2});
  endtask

  task automatic peek8(input logic [7:0] rc, input logic [7:0] cd);
    @(negedge CLK);
    st8 = 1'b0; ch8 = 1'b0; st16 = 1'b0; ch16 = 1'b0; rc8 = rc; cd8 = cd;
    #1;
  endtask

  task automatic drain();
    repeat (8) step(1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b1);
  endtask

  initial begin
    #1;
    for (int g = 0; g < 4; g++) begin
      check_eq("reset rdy_start", 64'(rs8[g]), 0);
      check_eq("reset rdy_result", 64'(rr8[g]), 0);
      check_eq("reset occupancy", 64'(occ8[g]), 0);
      check_eq("reset result", 64'(res8[g]), 0);
    end
    @(negedge CLK); @(negedge CLK); #2 RST_N = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    // Basic add with fixed operands and latency
    step(1, 0, 8'h10, 8'h05, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    peek8(8'h01, 8'hFF);
    check_eq("t1 rdy_result", 64'(rr8[0]), 1);
    check_eq("t1 result", 64'(res8[0]), 64'h16);
    check_eq("t1 check", 64'(ck8[0]), 64'hEA);
    step(0, 1, 0, 0, 8'h01, 8'hFF);
    step(0, 0, 0, 0, 0, 0);

    // Operator corner cases, one start per operator case
    step(1, 0, 8'hF0, 8'h20, 0, 0);
    step(1, 0, 8'h00, 8'h01, 0, 0);
    step(1, 0, 8'h10, 8'h11, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    peek8(0, 0);
    check_eq("t2 satadd", 64'(ck8[3]), 64'hFF);
    step(0, 1, 0, 0, 0, 0);
    peek8(0, 0);
    check_eq("t2 sub wrap", 64'(ck8[1]), 64'hFF);
    step(0, 1, 0, 0, 0, 0);
    peek8(0, 0);
    check_eq("t2 mul low", 64'(ck8[2]), 64'h10);
    drain();

    // Fill to DEPTH; fifth start must be ignored
    for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom), 8'($urandom), 0, 0);
    peek8(0, 0);
    check_eq("t3 occupancy full", 64'(occ8[0]), 4);
    check_eq("t3 rdy_start low", 64'(rs8[0]), 0);
    step(0, 1, 0, 0, 8'($urandom), 8'($urandom));
    step(0, 0, 0, 0, 0, 0);
    drain();

    // Streaming at occupancy 2
    step(1, 0, 8'($urandom), 8'($urandom), 0, 0);
    step(1, 0, 8'($urandom), 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++)
      step(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    peek8(0, 0);
    check_eq("t4 occupancy steady", 64'(occ8[0]), 2);
    drain();

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom), 8'($urandom), 0, 0, 1, 0, 16'($urandom), 16'($urandom));
    @(negedge CLK); #2 RST_N = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      check_eq("t5 rdy_start", 64'(rs8[g]), 0);
      check_eq("t5 rdy_result", 64'(rr8[g]), 0);
      check_eq("t5 rdy_check", 64'(rk8[g]), 0);
      check_eq("t5 occupancy", 64'(occ8[g]), 0);
    end
    check_eq("t5 occupancy w16", 64'(occ16), 0);
    q8.delete();
    q16.delete();
    #20;
    @(negedge CLK); #2 RST_N = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 8'h03, 8'h04, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    peek8(0, 0);
    check_eq("t5 fresh rdy", 64'(rr8[0]), 1);
    check_eq("t5 fresh value", 64'(res8[0]), 64'h07);
    check_eq("t5 fresh occupancy", 64'(occ8[0]), 1);
    drain();

    // DEPTH=3, WIDTH=16: repeated fill/drain wraps a non-power-of-2 queue
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 16'($urandom), 16'($urandom));
      peek8(0, 0);
      check_eq("t6 occupancy full", 64'(occ16), 3);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'($urandom), 16'h0);
    end
    drain();

    // Random mixed traffic on both widths
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50,
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
